// File: rtl/arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_D_WAIT = 2'd1,
        ARB_I_WAIT = 2'd2
    } arb_state_e;

    // Byte enables used for instruction fetches and data reads.
    localparam logic [3:0] BUS_SEL_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Datapath-port and external-bus signals of the memory port arbiter.
// slave: arbiter side; master: surrounding datapath + bus side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              rom_ce_i;
    logic [ADDR_W-1:0] rom_addr_i;
    logic [DATA_W-1:0] rom_data_o;
    logic              ram_ce_i;
    logic              ram_we_i;
    logic [ADDR_W-1:0] ram_addr_i;
    logic [3:0]        ram_sel_i;
    logic [DATA_W-1:0] ram_wdata_i;
    logic [DATA_W-1:0] ram_data_o;
    logic              pipe_stall_i;
    logic              stall_req_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_sel_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [DATA_W-1:0] bus_rdata_i;

    modport slave (
        input  rom_ce_i, rom_addr_i, ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_wdata_i,
        input  pipe_stall_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output rom_data_o, ram_data_o, stall_req_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o
    );

    modport master (
        output rom_ce_i, rom_addr_i, ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_wdata_i,
        output pipe_stall_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  rom_data_o, ram_data_o, stall_req_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o
    );

endinterface

// File: rtl/port_result_hold.sv
// Per-port "served" flag plus latched read data. The flag is set by a completed
// transaction (set_i for writes, capture_i for reads) and cleared when the pipeline
// advances; the data register only changes on capture.
module port_result_hold #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_i,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              done_o,
    output logic [DATA_W-1:0] data_o
);

    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state: completion wins over clear so a finished access is never lost.
    always_comb begin
        done_d = done_q;
        data_d = data_q;
        if (clear_i) begin
            done_d = 1'b0;
        end
        if (set_i || capture_i) begin
            done_d = 1'b1;
        end
        if (capture_i) begin
            data_d = data_i;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            done_q <= done_d;
            data_q <= data_d;
        end
    end

    assign done_o = done_q;
    assign data_o = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the fetch (rom) and data (ram) ports.
// Data accesses win; at most one bus transaction is outstanding.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.slave  port_if
);

    arb_state_e        state_q, state_d;
    logic              d_done, i_done;
    logic              d_pend, i_pend;
    logic              advance;
    logic              d_set, d_cap, i_cap;
    logic              req, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_sel;
    logic [DATA_W-1:0] req_wdata;

    assign d_pend              = port_if.ram_ce_i & ~d_done;
    assign i_pend              = port_if.rom_ce_i & ~i_done;
    assign port_if.stall_req_o = (d_pend | i_pend) & ~rst_i;
    // Pipeline moves on this edge: the next instruction's requests start fresh.
    assign advance             = ~port_if.stall_req_o & ~port_if.pipe_stall_i;

    // Bus request mux and FSM next-state; everything is quiet while in reset.
    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_sel   = '0;
        req_wdata = '0;
        d_set     = 1'b0;
        d_cap     = 1'b0;
        i_cap     = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (d_pend) begin
                        req       = 1'b1;
                        req_we    = port_if.ram_we_i;
                        req_addr  = port_if.ram_addr_i;
                        req_sel   = port_if.ram_we_i ? port_if.ram_sel_i : BUS_SEL_WORD;
                        req_wdata = port_if.ram_wdata_i;
                        if (port_if.bus_gnt_i) begin
                            if (port_if.ram_we_i) begin
                                d_set = 1'b1;
                            end else begin
                                state_d = ARB_D_WAIT;
                            end
                        end
                    end else if (i_pend) begin
                        req      = 1'b1;
                        req_addr = port_if.rom_addr_i;
                        req_sel  = BUS_SEL_WORD;
                        if (port_if.bus_gnt_i) begin
                            state_d = ARB_I_WAIT;
                        end
                    end
                end
                ARB_D_WAIT: begin
                    if (port_if.bus_rvalid_i) begin
                        d_cap   = 1'b1;
                        state_d = ARB_IDLE;
                    end
                end
                ARB_I_WAIT: begin
                    if (port_if.bus_rvalid_i) begin
                        i_cap   = 1'b1;
                        state_d = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    assign port_if.bus_req_o   = req;
    assign port_if.bus_we_o    = req_we;
    assign port_if.bus_addr_o  = req_addr;
    assign port_if.bus_sel_o   = req_sel;
    assign port_if.bus_wdata_o = req_wdata;

    // Arbiter state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    port_result_hold #(
        .DATA_W (DATA_W)
    ) u_data_hold (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .set_i     (d_set),
        .capture_i (d_cap),
        .clear_i   (advance),
        .data_i    (port_if.bus_rdata_i),
        .done_o    (d_done),
        .data_o    (port_if.ram_data_o)
    );

    port_result_hold #(
        .DATA_W (DATA_W)
    ) u_inst_hold (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .set_i     (1'b0),
        .capture_i (i_cap),
        .clear_i   (advance),
        .data_i    (port_if.bus_rdata_i),
        .done_o    (i_done),
        .data_o    (port_if.rom_data_o)
    );

endmodule
